// File: rtl/pe_array_mac_pkg.sv
// Shared constants, FSM encodings and width helpers for the PE array MAC.
package pe_array_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_DW    = 8;
  localparam int DEF_WW    = 8;
  localparam int DEF_ACCW  = 24;
  localparam int DEF_KMAX  = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACC    = 2'd1;
  localparam logic [1:0] ST_REDUCE = 2'd2;
  localparam logic [1:0] ST_OUT    = 2'd3;

  function automatic int calc_kw(input int kmax);
    return $clog2(kmax) + 1;
  endfunction

  function automatic int calc_ow(input int accw, input int lanes);
    return accw + $clog2(lanes);
  endfunction

endpackage

// File: rtl/pe_array_mac_if.sv
// Configuration, input-beat and result handshake bundle of the PE array.
interface pe_array_mac_if
  import pe_array_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int WW    = DEF_WW,
  parameter int ACCW  = DEF_ACCW,
  parameter int KMAX  = DEF_KMAX
);
  localparam int KW = calc_kw(KMAX);
  localparam int OW = calc_ow(ACCW, LANES);

  logic [KW-1:0]         cfg_taps;
  logic                  cfg_signed;
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data;
  logic [LANES*WW-1:0]   in_weight;
  logic                  out_valid;
  logic                  out_ready;
  logic [OW-1:0]         out_sum;
  logic [LANES*ACCW-1:0] out_lane;
  logic                  out_ovf;
  logic                  busy;

  modport master (
    output cfg_taps, cfg_signed, start, in_valid, in_data, in_weight, out_ready,
    input  in_ready, out_valid, out_sum, out_lane, out_ovf, busy
  );

  modport slave (
    input  cfg_taps, cfg_signed, start, in_valid, in_data, in_weight, out_ready,
    output in_ready, out_valid, out_sum, out_lane, out_ovf, busy
  );

endinterface

// File: rtl/pe_array_mac_pe_lane.sv
// One multiply-accumulate lane: mode-dependent extension, wrapping accumulator,
// sticky overflow flag.
module pe_lane #(
  parameter int DW   = 8,
  parameter int WW   = 8,
  parameter int ACCW = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            en,
  input  logic            signed_mode,
  input  logic [DW-1:0]   data,
  input  logic [WW-1:0]   weight,
  output logic [ACCW-1:0] acc,
  output logic            ovf
);
  localparam int PW = DW + WW;

  logic [PW-1:0]   op_a, op_b, prod;
  logic [ACCW-1:0] addend;
  logic [ACCW:0]   sum;
  logic            ovf_step;

  // Low PW bits of the product of PW-bit extended operands equal the true
  // signed or unsigned product, so one multiplier serves both modes.
  assign op_a = {{WW{signed_mode & data[DW-1]}}, data};
  assign op_b = {{DW{signed_mode & weight[WW-1]}}, weight};
  assign prod = op_a * op_b;

  assign addend = signed_mode ? ACCW'($signed(prod)) : ACCW'(prod);
  assign sum    = {1'b0, acc} + {1'b0, addend};

  always_comb begin
    ovf_step = sum[ACCW];
    if (signed_mode)
      ovf_step = (acc[ACCW-1] == addend[ACCW-1]) && (sum[ACCW-1] != acc[ACCW-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= sum[ACCW-1:0];
      ovf <= ovf | ovf_step;
    end
  end

endmodule

// File: rtl/pe_array_mac.sv
// Multi-lane convolution PE array: per-lane MACs over a tap window, then a
// registered reduction of all lanes into one result behind a valid/ready port.
//
//  state     | meaning
//  ST_IDLE   | waiting for start with nonzero taps
//  ST_ACC    | accepting beats until the tap count is reached
//  ST_REDUCE | summing lane accumulators into the result register
//  ST_OUT    | result held until the downstream accepts it
module pe_array_mac
  import pe_array_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DW    = DEF_DW,
  parameter int WW    = DEF_WW,
  parameter int ACCW  = DEF_ACCW,
  parameter int KMAX  = DEF_KMAX
) (
  input logic          clk,
  input logic          rst_n,
  pe_array_mac_if.slave bus
);
  localparam int KW = calc_kw(KMAX);
  localparam int OW = calc_ow(ACCW, LANES);

  logic [1:0]            state;
  logic [KW-1:0]         taps, count, taps_clamped;
  logic                  sgn;
  logic [OW-1:0]         sum_q, sum_d;
  logic [ACCW-1:0]       acc [LANES];
  logic [LANES-1:0]      ovf_l;
  logic [LANES*ACCW-1:0] lane_vec;
  logic                  start_ok, beat, last_beat;

  assign start_ok     = (state == ST_IDLE) && bus.start && (bus.cfg_taps != '0);
  assign beat         = (state == ST_ACC) && bus.in_valid;
  assign last_beat    = beat && (count == taps - 1'b1);
  assign taps_clamped = (bus.cfg_taps > KW'(KMAX)) ? KW'(KMAX) : bus.cfg_taps;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_lane #(.DW(DW), .WW(WW), .ACCW(ACCW)) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (start_ok),
      .en          (beat),
      .signed_mode (sgn),
      .data        (bus.in_data[i*DW +: DW]),
      .weight      (bus.in_weight[i*WW +: WW]),
      .acc         (acc[i]),
      .ovf         (ovf_l[i])
    );
    assign lane_vec[i*ACCW +: ACCW] = acc[i];
  end

  // Lanes are widened to OW before adding so the reduction never wraps.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sgn)
        sum_d = sum_d + {{(OW-ACCW){acc[i][ACCW-1]}}, acc[i]};
      else
        sum_d = sum_d + {{(OW-ACCW){1'b0}}, acc[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      taps  <= '0;
      count <= '0;
      sgn   <= 1'b0;
      sum_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state <= ST_ACC;
            taps  <= taps_clamped;
            sgn   <= bus.cfg_signed;
            count <= '0;
          end
        end
        ST_ACC: begin
          if (beat) count <= count + 1'b1;
          if (last_beat) state <= ST_REDUCE;
        end
        ST_REDUCE: begin
          sum_q <= sum_d;
          state <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_ACC);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_sum   = sum_q;
  assign bus.out_lane  = lane_vec;
  assign bus.out_ovf   = |ovf_l;

endmodule

// File: tb/tb_pe_array_mac.sv
// Bench for pe_array_mac: vector table plus scoreboard, with hand sequences for
// overflow, output hold, zero-tap start and mid-window reset.
module tb_pe_array_mac;
  import pe_array_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_array_mac_if #(.ACCW(24)) if0 ();
  pe_array_mac_if #(.ACCW(16)) if16 ();

  pe_array_mac #(.ACCW(24)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(if0));
  pe_array_mac #(.ACCW(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  typedef struct {
    logic [25:0] sum;
    logic [95:0] lanes;
    logic        ovf;
  } exp_t;

  typedef struct {
    bit          sgn;
    int          taps;
    logic [31:0] d;
    logic [31:0] w;
    int          gap;
  } vec_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact integer products, explicit mod-2^24 wrap and range tests.
  function automatic exp_t model(input bit sgn, input int taps, input logic [31:0] d,
                                 input logic [31:0] w);
    exp_t e;
    longint m = longint'(1) << 24;
    longint s = 0;
    int nt = (taps > 16) ? 16 : taps;
    e.lanes = '0;
    e.ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] di, wi;
      longint acc, p, sa, r;
      di = d[i*8 +: 8];
      wi = w[i*8 +: 8];
      acc = 0;
      for (int t = 0; t < nt; t++) begin
        if (sgn) begin
          p = longint'($signed(di)) * longint'($signed(wi));
          sa = (acc >= m/2) ? acc - m : acc;
          r = sa + p;
          if (r < -(m/2) || r >= m/2) e.ovf = 1'b1;
        end else begin
          p = longint'(di) * longint'(wi);
          r = acc + p;
          if (r >= m) e.ovf = 1'b1;
        end
        acc = (acc + p) & (m - 1);
      end
      e.lanes[i*24 +: 24] = acc[23:0];
      s += (sgn && acc >= m/2) ? acc - m : acc;
    end
    e.sum = s[25:0];
    return e;
  endfunction

  task automatic drive_window(input vec_t v);
    int nt = (v.taps > 16) ? 16 : v.taps;
    sb.push_back(model(v.sgn, v.taps, v.d, v.w));
    if0.cfg_taps = 5'(v.taps);
    if0.cfg_signed = v.sgn;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    check("busy_rise", 128'(if0.busy), 128'(1));
    for (int t = 0; t < nt; t++) begin
      if0.in_valid = 1'b1;
      if0.in_data = v.d;
      if0.in_weight = v.w;
      if (t == 0 || t == nt - 1) check("in_ready_acc", 128'(if0.in_ready), 128'(1));
      @(posedge clk); #1;
      if0.in_valid = 1'b0;
      if (t < nt - 1)
        repeat (v.gap) begin
          if0.in_data = ~v.d;
          check("in_ready_stall", 128'(if0.in_ready), 128'(1));
          @(posedge clk); #1;
        end
    end
    check("reduce_no_valid", 128'(if0.out_valid), 128'(0));
    check("reduce_no_ready", 128'(if0.in_ready), 128'(0));
  endtask

  task automatic expect_out(input int hold);
    exp_t e;
    int waited = 0;
    @(posedge clk); #1;
    check("out_latency", 128'(if0.out_valid), 128'(1));
    while (!if0.out_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!if0.out_valid) check("out_timeout", 128'(0), 128'(1));
    if (sb.size() == 0) begin
      check("sb_empty", 128'(0), 128'(1));
      return;
    end
    e = sb.pop_front();
    if (!if0.out_valid) return;
    check("out_sum", 128'(if0.out_sum), 128'(e.sum));
    check("out_lane", 128'(if0.out_lane), 128'(e.lanes));
    check("out_ovf", 128'(if0.out_ovf), 128'(e.ovf));
    for (int h = 0; h < hold; h++) begin
      if0.start = (h == 1);
      if0.cfg_taps = 5'd2;
      @(posedge clk); #1;
      check("hold_valid", 128'(if0.out_valid), 128'(1));
      check("hold_sum", 128'(if0.out_sum), 128'(e.sum));
      check("hold_lane", 128'(if0.out_lane), 128'(e.lanes));
      check("hold_in_ready", 128'(if0.in_ready), 128'(0));
    end
    if0.start = 1'b0;
    if0.out_ready = 1'b1;
    @(posedge clk); #1;
    if0.out_ready = 1'b0;
    check("accept_valid", 128'(if0.out_valid), 128'(0));
    check("accept_idle", 128'(if0.busy), 128'(0));
  endtask

  vec_t vecs[6];

  initial begin
    {if0.cfg_taps, if0.cfg_signed, if0.start, if0.in_valid, if0.in_data,
     if0.in_weight, if0.out_ready} = '0;
    {if16.cfg_taps, if16.cfg_signed, if16.start, if16.in_valid, if16.in_data,
     if16.in_weight, if16.out_ready} = '0;

    vecs[0] = '{0, 1,  {8'd64, 8'd48, 8'd32, 8'd16}, {8'd4, 8'd3, 8'd2, 8'd1}, 0};
    vecs[1] = '{0, 3,  {8'd64, 8'd48, 8'd32, 8'd16}, {8'd4, 8'd3, 8'd2, 8'd1}, 2};
    vecs[2] = '{1, 1,  32'hFFFF_FFFF, 32'h0202_0202, 0};
    vecs[3] = '{0, 1,  32'hFFFF_FFFF, 32'h0202_0202, 0};
    vecs[4] = '{1, 16, 32'hC001_7F80, 32'h40FF_807F, 1};
    vecs[5] = '{0, 20, 32'hA5C3_19FE, 32'h7E11_D2FF, 0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(if0.in_ready), 128'(0));
    check("rst_out_valid", 128'(if0.out_valid), 128'(0));
    check("rst_ovf", 128'(if0.out_ovf), 128'(0));
    check("rst_busy", 128'(if0.busy), 128'(0));
    check("rst_sum", 128'(if0.out_sum), 128'(0));
    check("rst_lane", 128'(if0.out_lane), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known-answer checks for the first vectors, independent of the model.
    check("kat_sum_t1", 128'(model(0, 1, vecs[0].d, vecs[0].w).sum), 128'(480));
    check("kat_sum_t3", 128'(model(0, 3, vecs[1].d, vecs[1].w).sum), 128'(1440));
    check("kat_sum_neg", 128'(model(1, 1, vecs[2].d, vecs[2].w).sum), 128'(26'h3FF_FFF8));

    for (int i = 0; i < 6; i++) begin
      drive_window(vecs[i]);
      expect_out(i == 0 ? 5 : 0);
    end

    // Zero-tap start is ignored.
    if0.cfg_taps = 5'd0;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    check("zero_taps_busy", 128'(if0.busy), 128'(0));
    @(posedge clk); #1;
    check("zero_taps_ready", 128'(if0.in_ready), 128'(0));

    // Narrow accumulator: 2 x 65025 wraps 16 bits with carry.
    if16.cfg_taps = 5'd2;
    if16.cfg_signed = 1'b0;
    if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    if16.in_data = 32'hFFFF_FFFF;
    if16.in_weight = 32'hFFFF_FFFF;
    if16.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if16.in_valid = 1'b0;
    @(posedge clk); #1;
    check("n16_valid", 128'(if16.out_valid), 128'(1));
    check("n16_ovf", 128'(if16.out_ovf), 128'(1));
    check("n16_lane", 128'(if16.out_lane), 128'({4{16'd64514}}));
    check("n16_sum", 128'(if16.out_sum), 128'(18'd258056));
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
    check("n16_idle", 128'(if16.busy), 128'(0));

    // Reset in the middle of a window.
    if0.cfg_taps = 5'd3;
    if0.cfg_signed = 1'b0;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    if0.in_valid = 1'b1;
    if0.in_data = vecs[0].d;
    if0.in_weight = vecs[0].w;
    @(posedge clk); #1;
    if0.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(if0.busy), 128'(0));
    check("abort_lane", 128'(if0.out_lane), 128'(0));
    check("abort_ready", 128'(if0.in_ready), 128'(0));
    check("abort_valid", 128'(if0.out_valid), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_stays_idle", 128'(if0.busy), 128'(0));
    drive_window(vecs[1]);
    expect_out(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
